aud_sample_fetch: RTL

AUD_SAMPLE_FETCH -- requirements
Module: aud_sample_fetch

---
 rtl/aud_sample_fetch.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/aud_sample_fetch.sv
// Audio sample fetcher: streams 32-bit ROM words through a small FIFO and
// unpacks them LSB-byte-first into 8-bit PCM samples at a fixed tick rate.
module aud_sample_fetch #(
  parameter int ROM_AW     = 8,
  parameter int ROM_WORDS  = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int TICK_DIV   = 2268,
  parameter bit LOOP       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aud_en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic [7:0]        sample,
  output logic              sample_stb,
  output logic              underrun,
  output logic              done
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [ROM_AW-1:0] LAST_ADDR = ROM_AW'(ROM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, REQ, CAP} fetch_state_t;

  // Each buffered word carries a marker telling the unpacker it is the final
  // word of a one-shot (LOOP=0) playback.
  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } entry_t;

  fetch_state_t state;
  logic         fetch_stop;
  logic         fetch_start;

  entry_t       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_count;
  logic         fifo_empty;
  logic         fifo_wr;
  logic         pop;
  entry_t       head;

  logic [TW-1:0] tick_cnt;
  logic         tick;

  logic         held;
  entry_t       word;
  logic [1:0]   idx;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_wr    = (state == CAP);
  assign head       = fifo_mem[rd_ptr];

  // In IDLE nothing is in flight, so the buffered count alone bounds occupancy.
  assign fetch_start = (state == IDLE) && aud_en && !done && !fetch_stop &&
                       (fifo_count < CW'(FIFO_DEPTH));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rom_addr   <= '0;
      fetch_stop <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fetch_start) state <= REQ;
        REQ:  state <= CAP;
        CAP: begin
          state <= IDLE;
          if (rom_addr == LAST_ADDR) begin
            if (LOOP) rom_addr   <= '0;
            else      fetch_stop <= 1'b1;
          end else begin
            rom_addr <= rom_addr + ROM_AW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the FIFO storage array is deliberately not reset; the pointers and
  // count define validity, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (!rst && fifo_wr) begin
      fifo_mem[wr_ptr] <= '{last: !LOOP && (rom_addr == LAST_ADDR), data: rom_data};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (fifo_wr) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      fifo_count <= fifo_count + CW'(fifo_wr) - CW'(pop);
    end
  end

  // Tick is registered one clk after the counter reaches TICK_DIV-1.
  always_ff @(posedge clk) begin
    if (rst || !aud_en) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (tick_cnt == TW'(TICK_DIV - 1)) begin
      tick_cnt <= '0;
      tick     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
      tick     <= 1'b0;
    end
  end

  always_comb begin
    // NOTE: default assignment first so every path drives pop and no latch
    // is inferred.
    pop = 1'b0;
    if (!done && !fifo_empty) pop = !held || (tick && idx == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      held       <= 1'b0;
      word       <= '0;
      idx        <= '0;
      sample     <= 8'h80;
      sample_stb <= 1'b0;
      underrun   <= 1'b0;
      done       <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      if (tick && !done) begin
        if (held) begin
          sample     <= word.data[{idx, 3'b000} +: 8];
          sample_stb <= 1'b1;
          idx        <= idx + 2'd1;
          if (idx == 2'd3) begin
            if (word.last) done <= 1'b1;
            held <= !fifo_empty;
            word <= head;
          end
        end else if (!fifo_empty) begin
          // Word arrives on the tick itself: emit byte 0 straight from the head.
          sample     <= head.data[7:0];
          sample_stb <= 1'b1;
          word       <= head;
          held       <= 1'b1;
          idx        <= 2'd1;
        end else begin
          underrun <= 1'b1;
        end
      end else if (!held && !fifo_empty && !done) begin
        word <= head;
        held <= 1'b1;
        idx  <= 2'd0;
      end
    end
  end

endmodule
